// File: rtl/resp_packet_tx.sv
// resp_packet_tx: serialises one ALU result into a framed little-endian
// response packet (opcode, reserved, LEN low, LEN high, result bytes LSB
// first, optional XOR checksum) on an AXI-Stream-style byte port.
// Optional feature macro: RESP_CHECKSUM_EN appends the XOR checksum byte.
module resp_packet_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    res_valid_i,
  output logic                    res_ready_o,
  input  logic [7:0]              res_opcode_i,
  input  logic [RESULT_WIDTH-1:0] res_data_i,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy_o
);

  localparam int NB    = RESULT_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
`ifdef RESP_CHECKSUM_EN
  localparam int LEN = 5 + NB;
`else
  localparam int LEN = 4 + NB;
`endif
  localparam logic [15:0]      LEN_W    = 16'(LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    OP,
    RSV,
    LEN_L,
    LEN_H,
    DATA
`ifdef RESP_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [RESULT_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              tdata_q, tdata_d;
  logic                    tvalid_q;
  logic                    accept;
`ifdef RESP_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
`endif

  assign accept = (state_q == IDLE) && res_valid_i;

  // State register; reset aborts any packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one step per byte handshake, acceptance only in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (res_valid_i)   state_d = OP;
      OP:    if (m_axis_tready) state_d = RSV;
      RSV:   if (m_axis_tready) state_d = LEN_L;
      LEN_L: if (m_axis_tready) state_d = LEN_H;
      LEN_H: if (m_axis_tready) state_d = DATA;
      DATA: begin
        if (m_axis_tready && (idx_q == IDX_LAST)) begin
`ifdef RESP_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef RESP_CHECKSUM_EN
      CSUM:  if (m_axis_tready) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic: status decode plus the next byte to present after each handshake
  always_comb begin
    res_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    tdata_d     = tdata_q;
    idx_d       = idx_q;
`ifdef RESP_CHECKSUM_EN
    csum_d      = csum_q;
    if (state_q != IDLE && m_axis_tready) csum_d = csum_q ^ tdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (res_valid_i) begin
          tdata_d = res_opcode_i;
          idx_d   = '0;
`ifdef RESP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      OP:    if (m_axis_tready) tdata_d = 8'h00;
      RSV:   if (m_axis_tready) tdata_d = LEN_W[7:0];
      LEN_L: if (m_axis_tready) tdata_d = LEN_W[15:8];
      LEN_H: begin
        if (m_axis_tready) begin
          tdata_d = data_q[7:0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (m_axis_tready) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef RESP_CHECKSUM_EN
            tdata_d = csum_q ^ tdata_q;
`else
            tdata_d = 8'h00;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            tdata_d = data_q[8*(int'(idx_q) + 1) +: 8];
          end
        end
      end
`ifdef RESP_CHECKSUM_EN
      CSUM: begin
        if (m_axis_tready) begin
          tdata_d = 8'h00;
          csum_d  = 8'h00;
        end
      end
`endif
      default: tdata_d = 8'h00;
    endcase
  end

  // Datapath registers: captured result, byte index, presented byte and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      idx_q    <= '0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
    end else begin
      if (accept) data_q <= res_data_i;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= (state_d != IDLE);
    end
  end

`ifdef RESP_CHECKSUM_EN
  // Running XOR of every byte already handed to the stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= 8'h00;
    else        csum_q <= csum_d;
  end
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;

endmodule
